// File: rtl/axi_mem_slave_if.sv
// AXI4 write/read channel bundle between a bus master and axi_mem_slave.
interface axi_mem_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, input AWREADY,
    output WDATA, WLAST, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARVALID, input ARREADY,
    input  RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, output AWREADY,
    input  WDATA, WLAST, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARVALID, output ARREADY,
    output RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI4 slave terminating INCR bursts (one at a time) onto a single-port synchronous memory.
// Illegal or out-of-range bursts run their full beat count but never touch memory and answer SLVERR.
module axi_mem_slave #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 16,
  parameter  int DEPTH      = 1024,
  localparam int BPB        = DATA_WIDTH / 8,
  localparam int SZ         = $clog2(BPB),
  localparam int MAW        = $clog2(DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_mem_slave_if.slave        axi,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MAW-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, W_DATA, W_RESP, R_ISSUE, R_CAPT, R_DATA} state_t;

  state_t                state, state_nxt;
  logic                  last_rd;
  logic [MAW-1:0]        word;
  logic [7:0]            len;
  logic [7:0]            cnt;
  logic                  err_addr;
  logic                  err_last;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  aw_hs, ar_hs, beat_end;

  // Evaluated one bit wider than the address so a burst near the top cannot wrap back into range.
  function automatic logic burst_err(logic [ADDR_WIDTH-1:0] addr, logic [7:0] blen, logic [2:0] size);
    logic [ADDR_WIDTH:0] last_word;
    last_word = {1'b0, addr >> SZ} + {{(ADDR_WIDTH-7){1'b0}}, blen};
    return (size != 3'(SZ)) || ((addr & ADDR_WIDTH'(BPB-1)) != '0) ||
           (last_word >= (ADDR_WIDTH+1)'(DEPTH));
  endfunction

  // On a tie the channel that was not granted last time wins; last_rd starts high so writes win first.
  assign axi.AWREADY = ARESETn && (state == IDLE) && axi.AWVALID && (!axi.ARVALID || last_rd);
  assign axi.ARREADY = ARESETn && (state == IDLE) && axi.ARVALID && (!axi.AWVALID || !last_rd);
  assign axi.RDATA   = rdata_q;

  assign aw_hs    = axi.AWVALID && axi.AWREADY;
  assign ar_hs    = axi.ARVALID && axi.ARREADY;
  assign beat_end = (cnt == len);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state    <= IDLE;
      last_rd  <= 1'b1;
      word     <= '0;
      len      <= '0;
      cnt      <= '0;
      err_addr <= 1'b0;
      err_last <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            word     <= MAW'(axi.AWADDR >> SZ);
            len      <= axi.AWLEN;
            cnt      <= '0;
            err_addr <= burst_err(axi.AWADDR, axi.AWLEN, axi.AWSIZE);
            err_last <= 1'b0;
            last_rd  <= 1'b0;
          end else if (ar_hs) begin
            word     <= MAW'(axi.ARADDR >> SZ);
            len      <= axi.ARLEN;
            cnt      <= '0;
            err_addr <= burst_err(axi.ARADDR, axi.ARLEN, axi.ARSIZE);
            err_last <= 1'b0;
            last_rd  <= 1'b1;
          end
        end
        W_DATA: begin
          // A misplaced WLAST only poisons the response; the beat count alone ends the burst.
          if (axi.WVALID) begin
            cnt <= cnt + 8'd1;
            if (axi.WLAST != beat_end) err_last <= 1'b1;
          end
        end
        R_CAPT: rdata_q <= err_addr ? '0 : mem_rdata;
        R_DATA: if (axi.RREADY && !beat_end) cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    axi.WREADY = 1'b0;
    axi.BVALID = 1'b0;
    axi.BRESP  = 2'b00;
    axi.RVALID = 1'b0;
    axi.RRESP  = 2'b00;
    axi.RLAST  = 1'b0;
    case (state)
      IDLE: begin
        if (aw_hs)      state_nxt = W_DATA;
        else if (ar_hs) state_nxt = R_ISSUE;
      end
      W_DATA: begin
        axi.WREADY = 1'b1;
        if (axi.WVALID) begin
          if (!err_addr) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = word + MAW'(cnt);
            mem_wdata = axi.WDATA;
          end
          if (beat_end) state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        axi.BVALID = 1'b1;
        axi.BRESP  = (err_addr || err_last) ? 2'b10 : 2'b00;
        if (axi.BREADY) state_nxt = IDLE;
      end
      R_ISSUE: begin
        if (!err_addr) begin
          mem_en   = 1'b1;
          mem_addr = word + MAW'(cnt);
        end
        state_nxt = R_CAPT;
      end
      R_CAPT: state_nxt = R_DATA;
      R_DATA: begin
        axi.RVALID = 1'b1;
        axi.RRESP  = err_addr ? 2'b10 : 2'b00;
        axi.RLAST  = beat_end;
        if (axi.RREADY) state_nxt = beat_end ? IDLE : R_ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomised scoreboard bench for axi_mem_slave: a word-array reference model predicts
// memory writes, B responses and R beats; negedge monitors compare whatever the DUT presents.
module tb_axi_mem_slave;
  localparam int DW = 32, AW = 16, DEPTH = 1024, MAW = 10;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  logic mem_en, mem_we;
  logic [MAW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  axi_mem_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi();

  axi_mem_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .axi(axi),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  // Memory the DUT drives, and the bench's own prediction of its contents.
  logic [DW-1:0] phys_mem [DEPTH] = '{default: '0};
  logic [DW-1:0] ref_mem  [DEPTH] = '{default: '0};

  always @(posedge ACLK) begin
    if (mem_en) begin
      if (mem_we) phys_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= phys_mem[mem_addr];
    end
  end

  typedef struct packed { logic [MAW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [DW-1:0] data; logic [1:0] resp; logic last; } rbeat_t;

  wr_t            wq[$];
  logic [MAW-1:0] raq[$];
  logic [1:0]     bq[$];
  rbeat_t         rq[$];
  logic [DW-1:0]  wdataQ[$];

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;

  always @(posedge ACLK) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic reportMissing(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: actual=event required=none (cycle %0d)", name, cycle);
  endtask

  function automatic bit isLegal(input int addr, input int len, input int size);
    return (size == 2) && (addr % 4 == 0) && (addr / 4 + len < DEPTH);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a memory access or a response.
  always @(negedge ACLK) begin : monitor
    wr_t    we;
    rbeat_t rb;
    if (ARESETn) begin
      if (mem_en && mem_we) begin
        if (wq.size() == 0) reportMissing("unexpected mem write");
        else begin
          we = wq.pop_front();
          checkOutput("mem write addr", mem_addr, we.addr);
          checkOutput("mem write data", mem_wdata, we.data);
        end
      end else if (mem_en) begin
        if (raq.size() == 0) reportMissing("unexpected mem read");
        else checkOutput("mem read addr", mem_addr, raq.pop_front());
      end
      if (axi.BVALID) begin
        if (bq.size() == 0) reportMissing("unexpected BVALID");
        else begin
          checkOutput("BRESP", axi.BRESP, bq[0]);
          if (axi.BREADY) void'(bq.pop_front());
        end
      end
      if (axi.RVALID) begin
        if (rq.size() == 0) reportMissing("unexpected RVALID");
        else begin
          rb = rq[0];
          checkOutput("RDATA", axi.RDATA, rb.data);
          checkOutput("RRESP", axi.RRESP, rb.resp);
          checkOutput("RLAST", axi.RLAST, rb.last);
          if (axi.RREADY) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " AWREADY"}, axi.AWREADY, 0);
    checkOutput({tag, " ARREADY"}, axi.ARREADY, 0);
    checkOutput({tag, " WREADY"},  axi.WREADY, 0);
    checkOutput({tag, " BVALID"},  axi.BVALID, 0);
    checkOutput({tag, " BRESP"},   axi.BRESP, 0);
    checkOutput({tag, " RVALID"},  axi.RVALID, 0);
    checkOutput({tag, " RDATA"},   axi.RDATA, 0);
    checkOutput({tag, " RRESP"},   axi.RRESP, 0);
    checkOutput({tag, " RLAST"},   axi.RLAST, 0);
    checkOutput({tag, " mem_en"},  mem_en, 0);
    checkOutput({tag, " mem_we"},  mem_we, 0);
    checkOutput({tag, " mem_addr"}, mem_addr, 0);
    checkOutput({tag, " mem_wdata"}, mem_wdata, 0);
  endtask

  // Presents an address and returns at #1 after the handshake edge; hs is the cycle that edge starts.
  task automatic applyStimulus(input bit isWrite, input int addr, input int len, input int size,
                               output bit ok, output int hs);
    @(posedge ACLK); #1;
    if (isWrite) begin
      axi.AWADDR = 16'(addr); axi.AWLEN = 8'(len); axi.AWSIZE = 3'(size); axi.AWVALID = 1'b1;
    end else begin
      axi.ARADDR = 16'(addr); axi.ARLEN = 8'(len); axi.ARSIZE = 3'(size); axi.ARVALID = 1'b1;
    end
    ok = 1'b0;
    hs = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge ACLK);
      if (isWrite ? axi.AWREADY : axi.ARREADY) begin
        ok = 1'b1;
        break;
      end
    end
    hs = cycle + 1;
    if (!ok) reportMissing(isWrite ? "AWREADY timeout" : "ARREADY timeout");
    @(posedge ACLK); #1;
    axi.AWVALID = 1'b0;
    axi.ARVALID = 1'b0;
  endtask

  task automatic writeData(input int addr, input int len, input int size, input int badLast);
    bit legal;
    bit done;
    bit seen;
    int lastCycle;
    legal = isLegal(addr, len, size);
    for (int i = 0; i <= len; i++) begin
      if (legal) begin
        wq.push_back('{addr: MAW'(addr / 4 + i), data: wdataQ[i]});
        ref_mem[addr / 4 + i] = wdataQ[i];
      end
    end
    bq.push_back((!legal || (badLast >= 0 && badLast <= len)) ? 2'b10 : 2'b00);
    @(negedge ACLK);
    checkOutput("WREADY after AW", axi.WREADY, 1);
    @(posedge ACLK); #1;
    lastCycle = 0;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, 2)) begin
        axi.WVALID = 1'b0;
        @(posedge ACLK); #1;
      end
      axi.WVALID = 1'b1;
      axi.WDATA  = wdataQ[i];
      axi.WLAST  = (i == len) ^ (i == badLast);
      done = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge ACLK);
        if (axi.WREADY) begin
          done = 1'b1;
          break;
        end
        @(posedge ACLK); #1;
      end
      if (!done) reportMissing("WREADY timeout");
      lastCycle = cycle;
      @(posedge ACLK); #1;
    end
    axi.WVALID = 1'b0;
    axi.WLAST  = 1'b0;
    done = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      axi.BREADY = ($urandom_range(0, 2) != 0);
      @(negedge ACLK);
      if (axi.BVALID && !seen) begin
        seen = 1'b1;
        checkOutput("BVALID latency", cycle, lastCycle + 1);
      end
      if (axi.BVALID && axi.BREADY) done = 1'b1;
      @(posedge ACLK); #1;
      if (done) break;
    end
    axi.BREADY = 1'b0;
    if (!done) reportMissing("B handshake timeout");
  endtask

  // mode 0: random RREADY, 1: toggle starting high, 2: always high.
  task automatic readData(input int addr, input int len, input int size, input int mode, input int hs);
    bit legal;
    bit first;
    int beats;
    legal = isLegal(addr, len, size);
    for (int i = 0; i <= len; i++) begin
      if (legal) raq.push_back(MAW'(addr / 4 + i));
      rq.push_back('{data: legal ? ref_mem[addr / 4 + i] : '0, resp: legal ? 2'b00 : 2'b10,
                     last: (i == len)});
    end
    first = 1'b1;
    beats = 0;
    for (int t = 0; t < 8 * (len + 1) + 50; t++) begin
      axi.RREADY = (mode == 0) ? ($urandom_range(0, 1) == 1) : (mode == 1) ? (t % 2 == 0) : 1'b1;
      @(negedge ACLK);
      if (axi.RVALID && first) begin
        first = 1'b0;
        checkOutput("RVALID latency", cycle, hs + 2);
      end
      if (axi.RVALID && axi.RREADY) beats++;
      @(posedge ACLK); #1;
      if (beats == len + 1) break;
    end
    axi.RREADY = 1'b0;
    if (beats != len + 1) reportMissing("R beats timeout");
  endtask

  task automatic writeBurst(input int addr, input int len, input int size, input int badLast);
    bit ok;
    int hs;
    applyStimulus(1'b1, addr, len, size, ok, hs);
    if (ok) writeData(addr, len, size, badLast);
  endtask

  task automatic readBurst(input int addr, input int len, input int size, input int mode);
    bit ok;
    int hs;
    applyStimulus(1'b0, addr, len, size, ok, hs);
    if (ok) readData(addr, len, size, mode, hs);
  endtask

  // Both address channels valid together; the expected winner is checked before the other is withdrawn.
  task automatic tieRound(input bit expectWrite, input int waddr, input int raddr);
    bit got;
    bit granted;
    int hs;
    @(posedge ACLK); #1;
    axi.AWADDR = 16'(waddr); axi.AWLEN = 8'd0; axi.AWSIZE = 3'd2; axi.AWVALID = 1'b1;
    axi.ARADDR = 16'(raddr); axi.ARLEN = 8'd0; axi.ARSIZE = 3'd2; axi.ARVALID = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge ACLK);
      if (axi.AWREADY || axi.ARREADY) begin
        got = 1'b1;
        break;
      end
    end
    hs = cycle + 1;
    granted = axi.AWREADY;
    if (!got) reportMissing("tie grant timeout");
    checkOutput("tie AWREADY", axi.AWREADY, expectWrite);
    checkOutput("tie ARREADY", axi.ARREADY, !expectWrite);
    @(posedge ACLK); #1;
    axi.AWVALID = 1'b0;
    axi.ARVALID = 1'b0;
    if (got && granted) begin
      wdataQ = {$urandom};
      writeData(waddr, 0, 2, -1);
    end else if (got) begin
      readData(raddr, 0, 2, 2, hs);
    end
  endtask

  initial begin
    bit ok;
    int hs;
    int isW, len, word, addr, size, kind, badLast;
    axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = '0; axi.AWVALID = 1'b1;
    axi.WDATA = '0; axi.WLAST = 1'b0; axi.WVALID = 1'b0; axi.BREADY = 1'b0;
    axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0; axi.ARVALID = 1'b1; axi.RREADY = 1'b0;
    #12;
    checkAllZero("reset");
    axi.AWVALID = 1'b0;
    axi.ARVALID = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1;

    $display("[TB] arbitration from reset");
    tieRound(1'b1, 32'h0200, 32'h0204);
    tieRound(1'b0, 32'h0208, 32'h0200);
    tieRound(1'b1, 32'h020C, 32'h0208);

    $display("[TB] directed bursts");
    wdataQ = {32'hDEADBEEF};
    writeBurst(32'h0010, 0, 2, -1);
    readBurst(32'h0010, 0, 2, 2);
    wdataQ = {32'd1, 32'd2, 32'd3, 32'd4};
    writeBurst(32'h0100, 3, 2, -1);
    readBurst(32'h0100, 3, 2, 1);
    wdataQ = {32'hAAAA0000, 32'hAAAA0001};
    writeBurst(32'h0FFC, 1, 2, -1);
    readBurst(32'h0010, 0, 1, 2);
    wdataQ = {32'h12345678};
    writeBurst(32'h0002, 0, 2, -1);
    wdataQ = {32'hCAFE0000, 32'hCAFE0001};
    writeBurst(32'h0300, 1, 2, 0);
    readBurst(32'h0300, 1, 2, 0);

    $display("[TB] 256-beat bursts at the top of memory");
    wdataQ = {};
    for (int i = 0; i < 256; i++) wdataQ.push_back($urandom);
    writeBurst(32'h0C00, 255, 2, -1);
    readBurst(32'h0C00, 255, 2, 2);
    writeBurst(32'h0C04, 255, 2, -1);

    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      isW  = $urandom_range(0, 1);
      len  = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 40) : $urandom_range(0, 7);
      kind = $urandom_range(0, 9);
      word = $urandom_range(0, 63);
      size = 2;
      addr = word * 4;
      if (kind == 0) addr = addr + $urandom_range(1, 3);
      if (kind == 1) size = $urandom_range(0, 1);
      if (kind == 2) addr = (DEPTH - len + $urandom_range(0, 3)) * 4;
      if (isW == 1) begin
        wdataQ = {};
        for (int i = 0; i <= len; i++) wdataQ.push_back($urandom);
        badLast = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
        writeBurst(addr, len, size, badLast);
      end else begin
        readBurst(addr, len, size, $urandom_range(0, 2));
      end
    end

    $display("[TB] reset during a read burst");
    applyStimulus(1'b0, 32'h0100, 3, 2, ok, hs);
    for (int i = 0; i < 4; i++) begin
      raq.push_back(MAW'(64 + i));
      rq.push_back('{data: ref_mem[64 + i], resp: 2'b00, last: (i == 3)});
    end
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge ACLK);
      if (axi.RVALID) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) reportMissing("RVALID before reset timeout");
    #2;
    ARESETn = 1'b0;
    axi.AWVALID = 1'b1;
    axi.ARVALID = 1'b1;
    #1;
    checkAllZero("mid-burst reset");
    rq.delete();
    raq.delete();
    axi.AWVALID = 1'b0;
    axi.ARVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    tieRound(1'b1, 32'h0400, 32'h0100);
    readBurst(32'h0400, 0, 2, 2);

    repeat (5) @(posedge ACLK);
    checkOutput("scoreboard drained", wq.size() + raq.size() + bq.size() + rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
